// File: rtl/rv32i_control_pkg.sv
// ============================================================================
// Module  : rv32i_control_pkg
// Brief   : Opcodes, control code constants and the control bundle type for
//           the RV32I execute unit.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package rv32i_control_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_SEC = 2'b11;

    localparam logic [1:0] SEC_NONE  = 2'b00;
    localparam logic [1:0] SEC_LUI   = 2'b01;
    localparam logic [1:0] SEC_AUIPC = 2'b10;
    localparam logic [1:0] SEC_JALR  = 2'b11;

    typedef struct packed {
        logic       mem_read;
        logic       mem_2_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [2:0] imm_src;
        logic [3:0] alu_ctrl;
        logic [1:0] wrt_back_src;
        logic [1:0] second_add_src;
    } ctrl_t;

    // alt selects SUB/SRA; callers pass only the func7 bit that is meaningful
    function automatic logic [3:0] alu_op_decode(input logic [2:0] func3, input logic alt);
        logic [3:0] op;
        case (func3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_exec_unit_alu.sv
// ============================================================================
// Module  : alu
// Brief   : Combinational RV32I integer ALU with zero and LSB flags.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module alu
    import rv32i_control_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             res_last_bit
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_SLT:  result[0] = $signed(a) < $signed(b);
            ALU_SLTU: result[0] = a < b;
            default:  result = '0;
        endcase
    end

    assign zero         = (result == '0);
    assign res_last_bit = result[0];

endmodule

`default_nettype wire

// File: rtl/rv32i_exec_unit.sv
// ============================================================================
// Module  : rv32i_exec_unit
// Brief   : RV32I control decode, ALU and word-addressed data memory.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rv32i_exec_unit #(
    parameter int DATA_WIDTH = rv32i_control_pkg::DATA_WIDTH,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  init_done,
    input  logic [9:0]            init_w_addr,
    input  logic [DATA_WIDTH-1:0] init_w_dat,
    input  logic                  init_w_enb,
    input  logic [9:0]            debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data,
    output logic [DATA_WIDTH-1:0] alu_results,
    output logic                  zero,
    output logic                  res_last_bit,
    output logic                  branch,
    output logic [2:0]            imm_src,
    output logic                  mem_read,
    output logic                  mem_2_reg,
    output logic [3:0]            alu_ctrl,
    output logic                  mem_write,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic [1:0]            wrt_back_src,
    output logic [1:0]            second_add_src,
    output logic [DATA_WIDTH-1:0] r_dat
);

    import rv32i_control_pkg::*;

    localparam int AW = $clog2(MEM_WORDS);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;

    assign opcode = instr[6:0];
    assign func3  = instr[14:12];
    assign func7  = instr[31:25];

    ctrl_t ctrl_raw;
    ctrl_t ctrl;
    logic  branch_raw;

    always_comb begin
        ctrl_raw = '0;
        case (opcode)
            OP_R: begin
                ctrl_raw.reg_write    = 1'b1;
                ctrl_raw.wrt_back_src = WB_ALU;
                ctrl_raw.alu_ctrl     = alu_op_decode(func3, func7[5]);
            end
            OP_I: begin
                ctrl_raw.alu_src      = 1'b1;
                ctrl_raw.imm_src      = IMM_I;
                ctrl_raw.reg_write    = 1'b1;
                ctrl_raw.wrt_back_src = WB_ALU;
                ctrl_raw.alu_ctrl     = alu_op_decode(func3, (func3 == 3'b101) && func7[5]);
            end
            OP_LOAD: begin
                ctrl_raw.alu_src      = 1'b1;
                ctrl_raw.imm_src      = IMM_I;
                ctrl_raw.mem_read     = 1'b1;
                ctrl_raw.mem_2_reg    = 1'b1;
                ctrl_raw.reg_write    = 1'b1;
                ctrl_raw.wrt_back_src = WB_MEM;
            end
            OP_STORE: begin
                ctrl_raw.alu_src   = 1'b1;
                ctrl_raw.imm_src   = IMM_S;
                ctrl_raw.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_raw.imm_src        = IMM_B;
                ctrl_raw.second_add_src = SEC_AUIPC;
                case (func3[2:1])
                    2'b00:   ctrl_raw.alu_ctrl = ALU_SUB;
                    2'b10:   ctrl_raw.alu_ctrl = ALU_SLT;
                    2'b11:   ctrl_raw.alu_ctrl = ALU_SLTU;
                    default: ctrl_raw.alu_ctrl = ALU_ADD;
                endcase
            end
            OP_JAL: begin
                ctrl_raw.imm_src        = IMM_J;
                ctrl_raw.second_add_src = SEC_AUIPC;
                ctrl_raw.reg_write      = 1'b1;
                ctrl_raw.wrt_back_src   = WB_PC4;
            end
            OP_JALR: begin
                ctrl_raw.imm_src        = IMM_I;
                ctrl_raw.second_add_src = SEC_JALR;
                ctrl_raw.reg_write      = 1'b1;
                ctrl_raw.wrt_back_src   = WB_PC4;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl_raw.imm_src        = IMM_U;
                ctrl_raw.second_add_src = (opcode == OP_LUI) ? SEC_LUI : SEC_AUIPC;
                ctrl_raw.reg_write      = 1'b1;
                ctrl_raw.wrt_back_src   = WB_SEC;
            end
            default: ctrl_raw = '0;
        endcase
    end

    // Kept apart from the main decode so the ALU flag feedback is not a comb loop
    always_comb begin
        branch_raw = 1'b0;
        case (opcode)
            OP_BRANCH: begin
                case (func3)
                    3'b000:         branch_raw = zero;
                    3'b001:         branch_raw = ~zero;
                    3'b100, 3'b110: branch_raw = res_last_bit;
                    3'b101, 3'b111: branch_raw = ~res_last_bit;
                    default:        branch_raw = 1'b0;
                endcase
            end
            OP_JAL, OP_JALR: branch_raw = 1'b1;
            default:         branch_raw = 1'b0;
        endcase
    end

    assign ctrl   = rst ? '0 : ctrl_raw;
    assign branch = ~rst & branch_raw;

    assign imm_src        = ctrl.imm_src;
    assign mem_read       = ctrl.mem_read;
    assign mem_2_reg      = ctrl.mem_2_reg;
    assign alu_ctrl       = ctrl.alu_ctrl;
    assign mem_write      = ctrl.mem_write;
    assign alu_src        = ctrl.alu_src;
    assign reg_write      = ctrl.reg_write;
    assign wrt_back_src   = ctrl.wrt_back_src;
    assign second_add_src = ctrl.second_add_src;

    // ALU runs from the ungated decode: its result is not held by reset
    logic [DATA_WIDTH-1:0] alu_b;
    assign alu_b = ctrl_raw.alu_src ? imm : rs2;

    alu #(
        .WIDTH        (DATA_WIDTH)
    ) u_alu (
        .alu_ctrl     (ctrl_raw.alu_ctrl),
        .a            (rs1),
        .b            (alu_b),
        .result       (alu_results),
        .zero         (zero),
        .res_last_bit (res_last_bit)
    );

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [AW-1:0]         w_addr;
    logic [DATA_WIDTH-1:0] w_dat;
    logic                  w_en;

    always_comb begin
        if (init_done) begin
            w_addr = alu_results[AW+1:2];
            w_dat  = rs2;
            w_en   = ctrl.mem_write;
        end else begin
            w_addr = init_w_addr[AW+1:2];
            w_dat  = init_w_dat;
            w_en   = init_w_enb & ~rst;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_dat;
        end
    end

    assign r_dat      = ctrl.mem_read ? mem[alu_results[AW+1:2]] : '0;
    assign debug_data = rst ? '0 : mem[debug_addr[AW+1:2]];

    logic unused_ok;
    assign unused_ok = &{1'b0, instr, init_w_addr, debug_addr, alu_results};

endmodule

`default_nettype wire

// File: tb/tb_rv32i_exec_unit.sv
// ============================================================================
// Module  : tb_rv32i_exec_unit
// Brief   : Directed-vector scoreboard bench for rv32i_exec_unit.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv32i_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0, rs1 = '0, rs2 = '0, imm = '0;
    logic        init_done = 1'b0;
    logic [9:0]  init_w_addr = '0;
    logic [31:0] init_w_dat = '0;
    logic        init_w_enb = 1'b0;
    logic [9:0]  debug_addr = '0;
    logic [31:0] debug_data, alu_results, r_dat;
    logic        zero, res_last_bit, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write;
    logic [2:0]  imm_src;
    logic [3:0]  alu_ctrl;
    logic [1:0]  wrt_back_src, second_add_src;

    always #5 clk = ~clk;

    rv32i_exec_unit #(.DATA_WIDTH(32), .MEM_WORDS(256)) dut (
        .clk(clk), .rst(rst), .instr(instr), .rs1(rs1), .rs2(rs2), .imm(imm),
        .init_done(init_done), .init_w_addr(init_w_addr), .init_w_dat(init_w_dat),
        .init_w_enb(init_w_enb), .debug_addr(debug_addr), .debug_data(debug_data),
        .alu_results(alu_results), .zero(zero), .res_last_bit(res_last_bit),
        .branch(branch), .imm_src(imm_src), .mem_read(mem_read), .mem_2_reg(mem_2_reg),
        .alu_ctrl(alu_ctrl), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .wrt_back_src(wrt_back_src),
        .second_add_src(second_add_src), .r_dat(r_dat)
    );

    localparam logic [3:0] S_ALU = 4'd0, S_ZERO = 4'd1, S_BR = 4'd2, S_CTRL = 4'd3,
                           S_RW = 4'd4, S_WB = 4'd5, S_MR = 4'd6, S_RDAT = 4'd7,
                           S_DBG = 4'd8, S_MW = 4'd9, S_IMM = 4'd10, S_SEC = 4'd11,
                           S_ASRC = 4'd12, S_M2R = 4'd13;

    typedef struct packed {
        logic [127:0] name;
        logic [3:0]   sel;
        logic [31:0]  val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic strobe = 1'b0;

    function automatic logic [31:0] observe(input logic [3:0] sel);
        case (sel)
            S_ALU:   return alu_results;
            S_ZERO:  return {31'd0, zero};
            S_BR:    return {31'd0, branch};
            S_CTRL:  return {28'd0, alu_ctrl};
            S_RW:    return {31'd0, reg_write};
            S_WB:    return {30'd0, wrt_back_src};
            S_MR:    return {31'd0, mem_read};
            S_RDAT:  return r_dat;
            S_DBG:   return debug_data;
            S_MW:    return {31'd0, mem_write};
            S_IMM:   return {29'd0, imm_src};
            S_SEC:   return {30'd0, second_add_src};
            S_ASRC:  return {31'd0, alu_src};
            default: return {31'd0, mem_2_reg};
        endcase
    endfunction

    // Monitor: drains the scoreboard whenever the driver marks outputs as presented
    always @(negedge clk) begin
        if (strobe) begin
            while (q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e   = q.pop_front();
                act = observe(e.sel);
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %0s actual=%h required=%h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic push(input logic [127:0] name, input logic [3:0] sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic present();
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
    endtask

    task automatic set_op(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im);
        instr = i;
        rs1   = a;
        rs2   = b;
        imm   = im;
    endtask

    task automatic init_write(input logic [9:0] a, input logic [31:0] d, input logic en);
        init_w_addr = a;
        init_w_dat  = d;
        init_w_enb  = en;
        @(posedge clk);
        #1;
        init_w_enb  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        set_op(32'h0062A3B3, 32'd8, 32'd10, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        push("rst_alu_ctrl", S_CTRL, 32'd0);
        push("rst_reg_write", S_RW, 32'd0);
        push("rst_wb_src", S_WB, 32'd0);
        push("rst_r_dat", S_RDAT, 32'd0);
        push("rst_debug", S_DBG, 32'd0);
        push("rst_alu_live", S_ALU, 32'd1);
        present();
        rst = 1'b0;

        init_write(10'd0, 32'h8, 1'b1);
        init_write(10'd4, 32'hA, 1'b1);
        init_write(10'd8, 32'h1, 1'b1);
        init_write(10'd0, 32'hDEAD, 1'b0);
        init_write(10'd4, 32'hBEEF, 1'b0);
        debug_addr = 10'd0; push("rd_0", S_DBG, 32'h8); present();
        debug_addr = 10'd4; push("rd_4", S_DBG, 32'hA); present();
        debug_addr = 10'd8; push("rd_8", S_DBG, 32'h1); present();

        set_op(32'h0062A3B3, 32'd8, 32'd10, 32'd0);
        push("slt_ctrl", S_CTRL, 32'h8);
        push("slt_res", S_ALU, 32'd1);
        push("slt_rw", S_RW, 32'd1);
        push("slt_wb", S_WB, 32'd1);
        push("slt_asrc", S_ASRC, 32'd0);
        present();
        set_op(32'h0062A3B3, 32'd10, 32'd8, 32'd0);
        push("slt_swap", S_ALU, 32'd0);
        push("slt_swap_zero", S_ZERO, 32'd1);
        present();

        set_op(32'h40000033, 32'd0, 32'd1, 32'd0);
        push("sub_ctrl", S_CTRL, 32'h1);
        push("sub_wrap", S_ALU, 32'hFFFFFFFF);
        present();
        set_op(32'h40005033, 32'h80000000, 32'd4, 32'd0);
        push("sra_ctrl", S_CTRL, 32'h7);
        push("sra_res", S_ALU, 32'hF8000000);
        present();
        set_op(32'h40005013, 32'h80000000, 32'd31, 32'h404);
        push("srai_ctrl", S_CTRL, 32'h7);
        push("srai_res", S_ALU, 32'hF8000000);
        push("srai_asrc", S_ASRC, 32'd1);
        present();
        set_op(32'h40000013, 32'd5, 32'd1, 32'h400);
        push("addi_f7_ctrl", S_CTRL, 32'h0);
        push("addi_f7_res", S_ALU, 32'h405);
        present();

        set_op(32'h00402083, 32'd0, 32'd0, 32'd4);
        push("lw_mr", S_MR, 32'd1);
        push("lw_rdat", S_RDAT, 32'hA);
        push("lw_wb", S_WB, 32'd0);
        push("lw_m2r", S_M2R, 32'd1);
        present();
        set_op(32'h00402083, 32'h400, 32'd0, 32'd6);
        push("lw_alias", S_RDAT, 32'hA);
        present();

        set_op(32'h00202423, 32'd0, 32'h55, 32'd8);
        init_done  = 1'b1;
        debug_addr = 10'd8;
        push("sw_mw", S_MW, 32'd1);
        push("sw_imm", S_IMM, 32'd1);
        push("sw_rw", S_RW, 32'd0);
        push("sw_old_data", S_DBG, 32'h1);
        present();
        set_op(32'h00000000, 32'd0, 32'd0, 32'd0);
        init_done = 1'b0;
        push("sw_new_data", S_DBG, 32'h55);
        push("nop_rdat", S_RDAT, 32'd0);
        present();

        set_op(32'h00000063, 32'd3, 32'd3, 32'd0);
        push("beq_br", S_BR, 32'd1);
        push("beq_imm", S_IMM, 32'd2);
        push("beq_sec", S_SEC, 32'd2);
        present();
        set_op(32'h00001063, 32'd3, 32'd3, 32'd0);
        push("bne_br", S_BR, 32'd0);
        present();
        set_op(32'h00004063, 32'hFFFFFFFF, 32'd1, 32'd0);
        push("blt_br", S_BR, 32'd1);
        push("blt_ctrl", S_CTRL, 32'h8);
        present();
        set_op(32'h00006063, 32'hFFFFFFFF, 32'd1, 32'd0);
        push("bltu_br", S_BR, 32'd0);
        push("bltu_ctrl", S_CTRL, 32'h9);
        present();
        set_op(32'h00005063, 32'hFFFFFFFF, 32'd1, 32'd0);
        push("bge_br", S_BR, 32'd0);
        present();

        set_op(32'h0000006F, 32'd0, 32'd0, 32'd0);
        push("jal_br", S_BR, 32'd1);
        push("jal_wb", S_WB, 32'd2);
        push("jal_imm", S_IMM, 32'd3);
        present();
        set_op(32'h00000067, 32'd0, 32'd0, 32'd0);
        push("jalr_sec", S_SEC, 32'd3);
        push("jalr_br", S_BR, 32'd1);
        present();
        set_op(32'h00000037, 32'd0, 32'd0, 32'd0);
        push("lui_wb", S_WB, 32'd3);
        push("lui_sec", S_SEC, 32'd1);
        push("lui_imm", S_IMM, 32'd4);
        present();
        set_op(32'h00000017, 32'd0, 32'd0, 32'd0);
        push("auipc_sec", S_SEC, 32'd2);
        present();
        set_op(32'h0000007F, 32'd1, 32'd2, 32'd3);
        push("bad_rw", S_RW, 32'd0);
        push("bad_br", S_BR, 32'd0);
        push("bad_asrc", S_ASRC, 32'd0);
        present();

        // Asynchronous reset raised between edges with an R-type applied
        set_op(32'h40000033, 32'd0, 32'd1, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        push("arst_ctrl", S_CTRL, 32'd0);
        push("arst_rw", S_RW, 32'd0);
        push("arst_wb", S_WB, 32'd0);
        push("arst_alu", S_ALU, 32'hFFFFFFFF);
        present();

        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv32i_exec_unit.md
RV32I_EXEC_UNIT -- requirements
Module: rv32i_exec_unit

Interface
Parameters, one per line: name, default, meaning.
REQ-001 DATA_WIDTH, 32, datapath width.
REQ-002 MEM_WORDS, 256, data memory depth in 32-bit words.
Ports, one per line: name, direction, width, meaning. clk and rst first.
REQ-003 clk  in  1  single clock; all state is updated on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 instr  in  32  current instruction; opcode=[6:0], func3=[14:12], func7=[31:25].
REQ-006 rs1, rs2, imm  in  32 each  register operands and sign-extended immediate.
REQ-007 init_done  in  1  0 = write port driven by init_w_addr[9:0], init_w_dat[31:0], init_w_enb; 1 = write port driven by alu_results, rs2, mem_write.
REQ-008 debug_addr  in  10 / debug_data  out  32  independent combinational read port.
REQ-009 alu_results  out  32; zero  out  1; res_last_bit  out  1.
REQ-010 Control outputs: branch 1, imm_src 3, mem_read 1, mem_2_reg 1, alu_ctrl 4, mem_write 1, alu_src 1, reg_write 1, wrt_back_src 2, second_add_src 2.
REQ-011 r_dat  out  32  data memory read result.

Function
REQ-012 Control is purely combinational from opcode, func3, func7, zero and res_last_bit.
REQ-013 alu_ctrl codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-014 imm_src codes: I 000, S 001, B 010, J 011, U 100.
REQ-015 wrt_back_src codes: MEM 00, ALU 01, PC+4 10, SEC 11.
REQ-016 second_add_src codes: NONE 00, LUI 01, AUIPC 10, JALR 11.
REQ-017 R-type (0110011): alu_src=0, reg_write=1, wrt_back_src=ALU.
- func7[5]=1 selects SUB for func3 000 and SRA for func3 101.
REQ-018 I-ALU (0010011): alu_src=1, imm_src=I, reg_write=1, wrt_back_src=ALU.
- func7[5] is used only for SRAI.
REQ-019 Load (0000011): ADD, alu_src=1, imm_src=I, mem_read=1, mem_2_reg=1, reg_write=1, wrt_back_src=MEM.
REQ-020 Store (0100011): ADD, alu_src=1, imm_src=S, mem_write=1, reg_write=0.
REQ-021 Branch (1100011): imm_src=B, alu_src=0, second_add_src=AUIPC, reg_write=0.
- BEQ/BNE use SUB; branch = zero / !zero.
- BLT/BGE use SLT; BLTU/BGEU use SLTU; branch = res_last_bit / !res_last_bit.
REQ-022 JAL (1101111): branch=1, imm_src=J, second_add_src=AUIPC, reg_write=1, wrt_back_src=PC+4.
REQ-023 JALR (1100111): branch=1, imm_src=I, second_add_src=JALR, reg_write=1, wrt_back_src=PC+4.
REQ-024 LUI (0110111): imm_src=U, second_add_src=LUI, reg_write=1, wrt_back_src=SEC.
REQ-025 AUIPC (0010111): same as LUI except second_add_src=AUIPC.
REQ-026 Any other opcode: all control outputs are 0.
REQ-027 ALU second operand is imm when alu_src=1, otherwise rs2.
REQ-028 ALU operation rules:
- Shifts use operand[4:0].
- SLT and SLTU return 0 or 1 in bit 0.
- Arithmetic wraps modulo 2^32.
REQ-029 zero = (alu_results==0); res_last_bit = alu_results[0].
REQ-030 Data memory word index = address[9:2]; address bits [1:0] and bits above [9] are ignored.
REQ-031 Memory write is synchronous on the rising clk edge when the selected write enable is 1.
REQ-032 Memory read is combinational: r_dat = mem[alu_results[9:2]] when mem_read=1, else 0.
REQ-033 A read and a write to the same address in the same cycle return the old data until the clock edge.

Reset
REQ-034 While rst=1, every control output, r_dat and debug_data is 0.
REQ-035 Reset does not clear the memory array; memory contents are undefined until written.
REQ-036 alu_results is combinational and is not gated by reset.

Structure
REQ-037 Opcode values and all alu_ctrl, imm_src, wrt_back_src and second_add_src code constants live in the shared package rv32i_control_pkg.
- DATA_WIDTH lives in the same package.
REQ-038 The ALU is a separate sub-module named alu.
REQ-039 Control decode and the memory array live in the top module.

Verification
REQ-040 Memory load and readback:
- Stimulus: init write 0x8, 0xA, 0x1 at byte addresses 0, 4, 8.
- Required: debug_data reads back each value; writes with init_w_enb=0 are ignored.
REQ-041 SLT:
- Stimulus: instr=0x0062A3B3 (slt x7,x5,x6), rs1=8, rs2=10.
- Required: alu_ctrl=1000, alu_results=1, reg_write=1, wrt_back_src=01.
- Swapped operands give alu_results=0.
REQ-042 Load:
- Stimulus: lw with imm=4 and rs1=0, after REQ-040.
- Required: mem_read=1, r_dat=0xA, wrt_back_src=00.
REQ-043 Store:
- Stimulus: sw with rs2=0x55, imm=8, init_done=1.
- Required: after one clk edge, debug_addr=8 returns 0x55.
REQ-044 Branches:
- Stimulus: beq with rs1=rs2=3.
- Required: branch=1; bne with the same operands gives branch=0.
- Stimulus: blt with rs1=-1, rs2=1.
- Required: branch=1; bltu with the same operands gives branch=0.
REQ-045 Reset:
- Stimulus: assert rst asynchronously mid-cycle while an R-type instruction is applied.
- Required: all control outputs drop to 0 without waiting for a clock edge.
